ex_mem_loader: RTL

EX_MEM_LOADER -- requirements
Module: ex_mem_loader

---
 rtl/ex_mem_loader_pkg.sv | 40 ++++
 rtl/ex_mem_loader_csum.sv | 25 ++
 rtl/ex_mem_loader.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ex_mem_loader_pkg.sv
// ex_mem_loader_pkg: shared widths, header field layout and FSM states for
// the external-memory image loader.
// Optional build macro: EX_MEM_LOADER_CSUM_EN adds the trailer checksum state.
package ex_mem_loader_pkg;

  localparam int ADDR_W      = 9;
  localparam int DATA_W      = 32;
  localparam int ENTRY_WORDS = 4;

  // Header word layout
  localparam int HDR_LAST_BIT  = 31;
  localparam int HDR_COUNT_MSB = 24;
  localparam int HDR_COUNT_LSB = 16;
  localparam int HDR_BASE_MSB  = 8;
  localparam int HDR_BASE_LSB  = 0;

  // Bits [30:25] and [15:9] must be zero in a well-formed header
  localparam logic [DATA_W-1:0] HDR_RSVD_MASK = 32'h7E00_FE00;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR,
    ST_W0,
    ST_W1,
    ST_W2,
    ST_W3,
    ST_COMMIT,
`ifdef EX_MEM_LOADER_CSUM_EN
    ST_CSUM,
`endif
    ST_DONE,
    ST_ERR
  } state_t;

  // A count field of zero stands for a full 512-entry segment
  function automatic logic [ADDR_W:0] hdr_count(input logic [ADDR_W-1:0] n);
    hdr_count = (n == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, n};
  endfunction

endpackage

// File: rtl/ex_mem_loader_csum.sv
// ex_mem_loader_csum: running XOR over the words of one load session.
// Only instantiated when EX_MEM_LOADER_CSUM_EN is defined.
module ex_mem_loader_csum
  import ex_mem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] sum
);

  // Clear wins over accumulate; the loader never asks for both at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (enable) begin
      sum <= sum ^ din;
    end
  end

endmodule

// File: rtl/ex_mem_loader.sv
// ex_mem_loader: parses a header/payload word stream and emits one write
// strobe per 4-word entry to the core's instruction/data external memories.
// Optional build macro: EX_MEM_LOADER_CSUM_EN (trailer checksum after the
// last segment; mismatch ends the session in ERR).
module ex_mem_loader
  import ex_mem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              enable_load_ex_mem,
  output logic [ADDR_W-1:0] InstExMemAddress,
  output logic [ADDR_W-1:0] DataExMemAddress,
  output logic [DATA_W-1:0] InstExMemData1,
  output logic [DATA_W-1:0] InstExMemData2,
  output logic [DATA_W-1:0] DataExMemData1,
  output logic [DATA_W-1:0] DataExMemData2,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              wrapped
);

  state_t state, next_state;

  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] out_addr;
  logic [ADDR_W:0]   remaining;
  logic              last_seg;
  logic [DATA_W-1:0] word_buf [ENTRY_WORDS-1];
  logic [DATA_W-1:0] i1_q, i2_q, d1_q, d2_q;
  logic              done_q;
  logic              wrapped_q;

  logic accept;
  logic start_ok;
  logic last_entry;
  logic hdr_ok;

  assign accept     = s_valid && s_ready;
  assign start_ok   = start && (state inside {ST_IDLE, ST_DONE, ST_ERR});
  assign last_entry = (remaining == {{ADDR_W{1'b0}}, 1'b1});
  assign hdr_ok     = ((s_data & HDR_RSVD_MASK) == '0);

`ifdef EX_MEM_LOADER_CSUM_EN
  logic [DATA_W-1:0] csum_value;
  logic              csum_match;

  ex_mem_loader_csum u_csum (
    .clk    (clk),
    .reset  (reset),
    .clear  (start_ok),
    .enable (accept && (state != ST_CSUM)),
    .din    (s_data),
    .sum    (csum_value)
  );

  assign csum_match = (s_data == csum_value);
  assign s_ready    = (state inside {ST_HDR, ST_W0, ST_W1, ST_W2, ST_W3, ST_CSUM});
`else
  assign s_ready    = (state inside {ST_HDR, ST_W0, ST_W1, ST_W2, ST_W3});
`endif

  assign busy               = s_ready || (state == ST_COMMIT);
  assign error              = (state == ST_ERR);
  assign enable_load_ex_mem = (state == ST_COMMIT);
  assign done               = done_q;
  assign wrapped            = wrapped_q;
  assign InstExMemAddress   = out_addr;
  assign DataExMemAddress   = out_addr;
  assign InstExMemData1     = i1_q;
  assign InstExMemData2     = i2_q;
  assign DataExMemData1     = d1_q;
  assign DataExMemData2     = d2_q;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state decode; in the word states s_ready is already high
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: if (start) next_state = ST_HDR;
      ST_HDR:    if (s_valid) next_state = hdr_ok ? ST_W0 : ST_ERR;
      ST_W0:     if (s_valid) next_state = ST_W1;
      ST_W1:     if (s_valid) next_state = ST_W2;
      ST_W2:     if (s_valid) next_state = ST_W3;
      ST_W3:     if (s_valid) next_state = ST_COMMIT;
      ST_COMMIT: begin
        if (!last_entry)    next_state = ST_W0;
        else if (!last_seg) next_state = ST_HDR;
`ifdef EX_MEM_LOADER_CSUM_EN
        else                next_state = ST_CSUM;
`else
        else                next_state = ST_DONE;
`endif
      end
`ifdef EX_MEM_LOADER_CSUM_EN
      ST_CSUM:   if (s_valid) next_state = csum_match ? ST_DONE : ST_ERR;
`endif
      default:   next_state = ST_IDLE;
    endcase
  end

  // Segment tracking: base address, entries left and LAST flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_addr  <= '0;
      remaining <= '0;
      last_seg  <= 1'b0;
    end else if (state == ST_HDR && accept && hdr_ok) begin
      cur_addr  <= s_data[HDR_BASE_MSB:HDR_BASE_LSB];
      remaining <= hdr_count(s_data[HDR_COUNT_MSB:HDR_COUNT_LSB]);
      last_seg  <= s_data[HDR_LAST_BIT];
    end else if (state == ST_COMMIT) begin
      cur_addr  <= cur_addr + 1'b1;
      remaining <= remaining - 1'b1;
    end
  end

  // Payload buffering; outputs only move when the fourth word lands
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRY_WORDS - 1; i++) word_buf[i] <= '0;
      out_addr <= '0;
      i1_q     <= '0;
      i2_q     <= '0;
      d1_q     <= '0;
      d2_q     <= '0;
    end else if (accept) begin
      case (state)
        ST_W0: word_buf[0] <= s_data;
        ST_W1: word_buf[1] <= s_data;
        ST_W2: word_buf[2] <= s_data;
        ST_W3: begin
          out_addr <= cur_addr;
          i1_q     <= word_buf[0];
          i2_q     <= word_buf[1];
          d1_q     <= word_buf[2];
          d2_q     <= s_data;
        end
        default: ;
      endcase
    end
  end

  // Status flags: done pulses on DONE entry, wrapped is sticky until start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q    <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      done_q <= (next_state == ST_DONE) && (state != ST_DONE);
      if (start_ok)
        wrapped_q <= 1'b0;
      else if (state == ST_COMMIT && cur_addr == '1 && !last_entry)
        wrapped_q <= 1'b1;
    end
  end

endmodule
